// File: rtl/alu_dp_gen.sv
// Accumulator/B-register datapath with GPR file and handshaked output port.
// Optional carry-in opcodes (0xC/0xD) built only when ALU_DP_ADC_EN is defined.
module alu_dp_gen #(
  parameter int WIDTH = 4,
  parameter int NGPR  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH+3:0] instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WIDTH-1:0] in_port,
  output logic             cflag,
  output logic [WIDTH-1:0] A_reg_out,
  output logic [WIDTH-1:0] B_reg_out,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid,
  input  logic             out_ack
);

  localparam int IW = (NGPR > 1) ? $clog2(NGPR) : 1;

  localparam logic [3:0] OP_MVA = 4'h0;
  localparam logic [3:0] OP_MVB = 4'h1;
  localparam logic [3:0] OP_ADA = 4'h2;
  localparam logic [3:0] OP_ADB = 4'h3;
  localparam logic [3:0] OP_BTA = 4'h4;
  localparam logic [3:0] OP_ATB = 4'h5;
  localparam logic [3:0] OP_INA = 4'h6;
  localparam logic [3:0] OP_INB = 4'h7;
  localparam logic [3:0] OP_OUI = 4'h8;
  localparam logic [3:0] OP_OUB = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_LD  = 4'hB;
`ifdef ALU_DP_ADC_EN
  localparam logic [3:0] OP_ACA = 4'hC;
  localparam logic [3:0] OP_ACB = 4'hD;
`endif

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             c_q, c_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] gpr_q [NGPR];

  logic [3:0]       op;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] src;
  logic [IW-1:0]    idx;
  logic [WIDTH:0]   sum;
  logic             acc;
  logic             arith;
  logic             wa, wb, wo;
  logic             st, ld;
`ifdef ALU_DP_ADC_EN
  logic             cin;
`endif

  assign op  = instr[WIDTH+3:WIDTH];
  assign imm = instr[WIDTH-1:0];
  assign idx = imm[IW-1:0];

  assign instr_ready = !ov_q || out_ack;
  assign acc         = instr_valid && instr_ready;

  always_comb begin
    src   = '0;
    arith = 1'b0;
    wa    = 1'b0;
    wb    = 1'b0;
    wo    = 1'b0;
    st    = 1'b0;
    ld    = 1'b0;
`ifdef ALU_DP_ADC_EN
    cin   = 1'b0;
`endif
    case (op)
      OP_MVA: begin arith = 1'b1; wa = 1'b1; end
      OP_MVB: begin arith = 1'b1; wb = 1'b1; end
      OP_ADA: begin arith = 1'b1; wa = 1'b1; src = a_q; end
      OP_ADB: begin arith = 1'b1; wb = 1'b1; src = b_q; end
      OP_BTA: begin arith = 1'b1; wa = 1'b1; src = b_q; end
      OP_ATB: begin arith = 1'b1; wb = 1'b1; src = a_q; end
      OP_INA: begin arith = 1'b1; wa = 1'b1; src = in_port; end
      OP_INB: begin arith = 1'b1; wb = 1'b1; src = in_port; end
      OP_OUI: begin arith = 1'b1; wo = 1'b1; end
      OP_OUB: begin arith = 1'b1; wo = 1'b1; src = b_q; end
      OP_ST:  st = 1'b1;
      OP_LD:  ld = 1'b1;
`ifdef ALU_DP_ADC_EN
      OP_ACA: begin
        arith = 1'b1; wa = 1'b1; src = a_q; cin = c_q;
      end
      OP_ACB: begin
        arith = 1'b1; wb = 1'b1; src = b_q; cin = c_q;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_DP_ADC_EN
  assign sum = {1'b0, src} + {1'b0, imm}
             + {{WIDTH{1'b0}}, cin};
`else
  assign sum = {1'b0, src} + {1'b0, imm};
`endif

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    c_d  = c_q;
    o_d  = o_q;
    ov_d = ov_q;
    if (acc) begin
      if (arith) c_d = sum[WIDTH];
      if (wa)    a_d = sum[WIDTH-1:0];
      if (wb)    b_d = sum[WIDTH-1:0];
      if (ld)    b_d = gpr_q[idx];
    end
    // A new OUT op wins over an acknowledge in the same cycle.
    if (acc && wo) begin
      o_d  = sum[WIDTH-1:0];
      ov_d = 1'b1;
    end else if (out_ack) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      o_q  <= '0;
      c_q  <= 1'b0;
      ov_q <= 1'b0;
      for (int i = 0; i < NGPR; i++) gpr_q[i] <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      o_q  <= o_d;
      c_q  <= c_d;
      ov_q <= ov_d;
      if (acc && st) gpr_q[idx] <= b_q;
    end
  end

  assign cflag     = c_q;
  assign A_reg_out = a_q;
  assign B_reg_out = b_q;
  assign out_port  = o_q;
  assign out_valid = ov_q;

endmodule
